// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data memory controller.
//   F3_*     : RISC-V funct3 encodings for load/store widths
//   state_t  : controller FSM states
package mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane logic for the data memory controller.
// Ports:
//   funct3      in  3   access width / signedness
//   lane        in  2   byte offset within the word (addr[1:0])
//   load_word   in  32  word read from RAM for a load
//   old_word    in  32  word read from RAM during read-modify-write
//   store_data  in  32  CPU store data (low bits used for SB/SH)
//   load_data   out 32  extracted and sign/zero-extended load result
//   merged_word out 32  word to write back for a store
module byte_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Shift the addressed byte/halfword down to bit 0 before extending.
  always_comb begin
    byte_shifted = load_word >> {lane, 3'b000};
    half_shifted = load_word >> {lane[1], 4'b0000};
    byte_val     = byte_shifted[7:0];
    half_val     = half_shifted[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_data = {24'h000000, byte_val};
      F3_H:    load_data = {{16{half_val[15]}}, half_val};
      F3_HU:   load_data = {16'h0000, half_val};
      default: load_data = load_word;
    endcase
  end

  // Sub-word stores keep the untouched bytes from the RMW read.
  always_comb begin
    merged_word = old_word;
    case (funct3)
      F3_B:    merged_word[{lane, 3'b000} +: 8]    = store_data[7:0];
      F3_H:    merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: sequences CPU loads/stores into the data RAM.
// Sub-word stores use read-modify-write because the RAM always writes a
// full word. Out-of-range, misaligned or undefined accesses return a fault
// without touching the RAM.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag and access width
//   req_addr, req_wdata      byte address and store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_fault   load result / fault flag
//   ram_addr, ram_we         word-aligned RAM address and write enable
//   ram_wdata, ram_rdata     RAM write word / combinational read word
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_BASE    = 'h1000,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_TOP     = 'h1FFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_fault,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  state_t                     state;
  logic [2:0]                 funct3_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [31:0]                wdata_q;
  logic [31:0]                merge_q;
  logic                       write_q;

  logic [ADDRESS_WIDTH-1:0]   span;
  logic                       in_range;
  logic                       misaligned;
  logic                       bad_funct3;
  logic                       fault;
  logic [31:0]                load_data;
  logic [31:0]                merged_word;

  // Range check compares the distance to RAM_TOP against the access span,
  // so an address near the top of the address space cannot wrap.
  always_comb begin
    case (req_funct3)
      F3_H, F3_HU: span = ADDRESS_WIDTH'(1);
      F3_W:        span = ADDRESS_WIDTH'(3);
      default:     span = '0;
    endcase
    in_range   = (req_addr >= RAM_BASE) && (req_addr <= RAM_TOP) &&
                 ((RAM_TOP - req_addr) >= span);
    misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    if (req_we)
      bad_funct3 = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W));
    else
      bad_funct3 = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                     (req_funct3 == F3_BU) || (req_funct3 == F3_HU));
    fault = !in_range || misaligned || bad_funct3;
  end

  byte_lane_unit u_lanes (
    .funct3      (funct3_q),
    .lane        (addr_q[1:0]),
    .load_word   (ram_rdata),
    .old_word    (merge_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // RAM address is only driven while the RAM is actually being accessed.
  // The write enable is gated by rst so a reset during WRITE never writes.
  always_comb begin
    if ((state == LOAD) || (state == RMW_RD) || (state == WRITE))
      ram_addr = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
    else
      ram_addr = '0;
    ram_we    = write_q && !rst;
    ram_wdata = (state == WRITE) ? merged_word : 32'h0;
  end

  // Main FSM; handshake and response outputs are registered so they
  // follow the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'h0;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              state   <= WRITE;
              write_q <= 1'b1;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          merge_q <= ram_rdata;
          write_q <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          write_q    <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          write_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
